// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU data-memory master.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_e;

    localparam int BYTE_MASK_W = 4;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane helper: store mask and data shift, load extract and sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e                size,
    input  logic [1:0]               off,
    input  logic                     uns,
    input  logic [31:0]              wdata,
    input  logic [31:0]              rdata,
    output logic [BYTE_MASK_W-1:0]   wmask,
    output logic [31:0]              wdata_sh,
    output logic [31:0]              rdata_ext
);

    logic [31:0] raw;

    always_comb begin
        raw       = rdata >> {off, 3'b000};
        wdata_sh  = wdata << {off, 3'b000};
        wmask     = 4'b1111;
        rdata_ext = raw;
        case (size)
            SZ_B: begin
                wmask     = 4'b0001 << off;
                rdata_ext = uns ? {24'b0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            end
            SZ_H: begin
                wmask     = 4'b0011 << off;
                rdata_ext = uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            end
            default: begin
                wmask     = 4'b1111;
                rdata_ext = raw;
            end
        endcase
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// LSU data-memory master: one outstanding load/store held MEM_LATENCY cycles on dmem_*.
// Build macro LSU_MISALIGN_TRAP_EN turns misaligned/reserved-size requests into error responses.
module lsu_dmem_master
    import lsu_pkg::*;
#(
    parameter int MEM_LATENCY = 1
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_wen,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_rdata,
    output logic                     resp_err,
    output logic                     dmem_valid,
    output logic [31:0]              dmem_addr,
    output logic [31:0]              dmem_wdata,
    output logic                     dmem_wen,
    output logic [BYTE_MASK_W-1:0]   dmem_wmask,
    input  logic [31:0]              dmem_rdata
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    lsu_state_e              state;
    logic [CW-1:0]           cnt;
    logic                    wen_q;
    logic                    uns_q;
    lsu_size_e               size_q;
    logic [1:0]              off_q;

    lsu_size_e               req_sz;
    lsu_size_e               eff_size;
    logic [1:0]              eff_off;
    logic                    req_err;
    logic                    cnt_last;
    logic                    cnt_pre_last;

    lsu_size_e               al_size;
    logic [1:0]              al_off;
    logic                    al_uns;
    logic [BYTE_MASK_W-1:0]  al_wmask;
    logic [31:0]             al_wdata;
    logic [31:0]             al_rdata;

    // Reserved size behaves as a word; the offset is aligned down to the access size.
    always_comb begin
        req_sz   = lsu_size_e'(req_size);
        eff_size = (req_sz == SZ_RSV) ? SZ_W : req_sz;
        case (eff_size)
            SZ_H:    eff_off = {req_addr[1], 1'b0};
            SZ_W:    eff_off = 2'b00;
            default: eff_off = req_addr[1:0];
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err = (req_sz == SZ_RSV)
                  || (req_sz == SZ_H && req_addr[0])
                  || (req_sz == SZ_W && req_addr[1:0] != 2'b00);
`else
    assign req_err = 1'b0;
`endif

    assign cnt_last     = (int'(cnt) == MEM_LATENCY - 1);
    assign cnt_pre_last = (int'(cnt) == MEM_LATENCY - 2);

    // One aligner serves both directions: request fields while idle, captured fields during the access.
    assign al_size = (state == IDLE) ? eff_size     : size_q;
    assign al_off  = (state == IDLE) ? eff_off      : off_q;
    assign al_uns  = (state == IDLE) ? req_unsigned : uns_q;

    lsu_align u_align (
        .size      (al_size),
        .off       (al_off),
        .uns       (al_uns),
        .wdata     (req_wdata),
        .rdata     (dmem_rdata),
        .wmask     (al_wmask),
        .wdata_sh  (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wen_q      <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= SZ_B;
            off_q      <= 2'b00;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            dmem_valid <= 1'b0;
            dmem_wen   <= 1'b0;
            dmem_wmask <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        wen_q      <= req_wen;
                        size_q     <= eff_size;
                        uns_q      <= req_unsigned;
                        off_q      <= eff_off;
                        cnt        <= '0;
                        dmem_addr  <= {req_addr[31:2], 2'b00};
                        dmem_wdata <= al_wdata;
                        dmem_wmask <= al_wmask;
                        resp_err   <= req_err;
                        resp_rdata <= '0;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            dmem_valid <= 1'b1;
                            dmem_wen   <= req_wen && (MEM_LATENCY == 1);
                            state      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // The write strobe is only ever up on the final access cycle.
                    if (cnt_last) begin
                        resp_rdata <= wen_q ? '0 : al_rdata;
                        resp_valid <= 1'b1;
                        dmem_valid <= 1'b0;
                        dmem_wen   <= 1'b0;
                        state      <= RESP;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        dmem_wen <= wen_q && cnt_pre_last;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master: instances with MEM_LATENCY 1 and 3 checked against a byte-level memory model.
// Expectations follow LSU_MISALIGN_TRAP_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_lsu_dmem_master;

    localparam int N         = 2;
    localparam int RAM_WORDS = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst          [N];
    logic        req_valid    [N];
    logic        req_ready    [N];
    logic        req_wen      [N];
    logic [1:0]  req_size     [N];
    logic        req_unsigned [N];
    logic [31:0] req_addr     [N];
    logic [31:0] req_wdata    [N];
    logic        resp_valid   [N];
    logic        resp_ready   [N];
    logic [31:0] resp_rdata   [N];
    logic        resp_err     [N];
    logic        dmem_valid   [N];
    logic [31:0] dmem_addr    [N];
    logic [31:0] dmem_wdata   [N];
    logic        dmem_wen     [N];
    logic [3:0]  dmem_wmask   [N];
    logic [31:0] dmem_rdata   [N];

    logic [31:0] ram      [N][RAM_WORDS];
    logic [7:0]  ref_mem  [N][RAM_WORDS*4];
    int          wr_count [N];
    logic        ram_init;
    logic [31:0] merged;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        lsu_dmem_master #(.MEM_LATENCY((g == 0) ? 1 : 3)) dut (
            .clk          (clk),
            .rst          (rst[g]),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_wen      (req_wen[g]),
            .req_size     (req_size[g]),
            .req_unsigned (req_unsigned[g]),
            .req_addr     (req_addr[g]),
            .req_wdata    (req_wdata[g]),
            .resp_valid   (resp_valid[g]),
            .resp_ready   (resp_ready[g]),
            .resp_rdata   (resp_rdata[g]),
            .resp_err     (resp_err[g]),
            .dmem_valid   (dmem_valid[g]),
            .dmem_addr    (dmem_addr[g]),
            .dmem_wdata   (dmem_wdata[g]),
            .dmem_wen     (dmem_wen[g]),
            .dmem_wmask   (dmem_wmask[g]),
            .dmem_rdata   (dmem_rdata[g])
        );
        assign dmem_rdata[g] = ram[g][dmem_addr[g][7:2]];
    end

    function automatic logic [31:0] init_word(input int w);
        if (w == 0) return 32'h8001_1234;
        return (32'(w) * 32'h0103_0507) ^ 32'h5A3C_C3A5;
    endfunction

    // RAM side of the memory port: writes masked lanes on every valid&wen edge.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (ram_init) begin
                for (int w = 0; w < RAM_WORDS; w++) ram[i][w] <= init_word(w);
                wr_count[i] <= 0;
            end else if (dmem_valid[i] && dmem_wen[i]) begin
                merged = ram[i][dmem_addr[i][7:2]];
                for (int b = 0; b < 4; b++)
                    if (dmem_wmask[i][b]) merged[8*b +: 8] = dmem_wdata[i][8*b +: 8];
                ram[i][dmem_addr[i][7:2]] <= merged;
                wr_count[i] <= wr_count[i] + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction with cycle-by-cycle checks against the byte-level model.
    task automatic applyStimulus(input int idx, input bit wen, input logic [1:0] size, input bit uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int resp_delay, output logic [31:0] obs_rdata);
        int lat, nbytes, ea, wc0;
        bit err;
        logic [31:0] exp_rdata, exp_wdata;
        logic [3:0]  exp_mask;
        lat    = (idx == 0) ? 1 : 3;
        nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
        err = (size == 2'b11) || (addr % nbytes != 0);
`else
        err = 1'b0;
`endif
        ea        = int'(addr[7:0]) / nbytes * nbytes;
        exp_mask  = '0;
        exp_rdata = '0;
        exp_wdata = wdata << (8 * (ea % 4));
        for (int b = 0; b < nbytes; b++) begin
            exp_mask[(ea + b) % 4] = 1'b1;
            if (!wen && !err) exp_rdata[8*b +: 8] = ref_mem[idx][ea + b];
        end
        if (!wen && !err && nbytes < 4 && !uns && exp_rdata[8*nbytes-1])
            for (int b = nbytes; b < 4; b++) exp_rdata[8*b +: 8] = 8'hFF;
        if (wen && !err)
            for (int b = 0; b < nbytes; b++) ref_mem[idx][ea + b] = wdata[8*b +: 8];

        @(negedge clk);
        checkOutput("req_ready_idle", 32'(req_ready[idx]), 32'd1);
        wc0                = wr_count[idx];
        req_valid[idx]     = 1'b1;
        req_wen[idx]       = wen;
        req_size[idx]      = size;
        req_unsigned[idx]  = uns;
        req_addr[idx]      = addr;
        req_wdata[idx]     = wdata;
        @(negedge clk);
        req_valid[idx]     = 1'b0;
        req_addr[idx]      = $urandom();
        req_wdata[idx]     = $urandom();
        req_size[idx]      = 2'($urandom_range(0, 3));
        req_unsigned[idx]  = 1'($urandom_range(0, 1));

        if (err) begin
            checkOutput("err_no_access", 32'(dmem_valid[idx]), 32'd0);
            checkOutput("err_flag", 32'(resp_err[idx]), 32'd1);
        end else begin
            for (int k = 1; k <= lat; k++) begin
                checkOutput("dmem_valid", 32'(dmem_valid[idx]), 32'd1);
                checkOutput("dmem_wen", 32'(dmem_wen[idx]), 32'(wen && k == lat));
                checkOutput("dmem_addr", dmem_addr[idx], addr & 32'hFFFF_FFFC);
                checkOutput("dmem_wmask", 32'(dmem_wmask[idx]), 32'(exp_mask));
                checkOutput("dmem_wdata", dmem_wdata[idx], exp_wdata);
                checkOutput("busy_req_ready", 32'(req_ready[idx]), 32'd0);
                checkOutput("early_resp", 32'(resp_valid[idx]), 32'd0);
                @(negedge clk);
            end
            checkOutput("resp_err", 32'(resp_err[idx]), 32'd0);
        end
        checkOutput("resp_valid", 32'(resp_valid[idx]), 32'd1);
        checkOutput("access_done", 32'(dmem_valid[idx]), 32'd0);
        checkOutput("resp_rdata", resp_rdata[idx], exp_rdata);
        obs_rdata = resp_rdata[idx];
        for (int d = 0; d < resp_delay; d++) begin
            @(negedge clk);
            checkOutput("resp_hold_valid", 32'(resp_valid[idx]), 32'd1);
            checkOutput("resp_hold_rdata", resp_rdata[idx], exp_rdata);
            checkOutput("resp_hold_err", 32'(resp_err[idx]), 32'(err));
            checkOutput("resp_hold_ready", 32'(req_ready[idx]), 32'd0);
        end
        resp_ready[idx] = 1'b1;
        @(negedge clk);
        resp_ready[idx] = 1'b0;
        checkOutput("resp_released", 32'(resp_valid[idx]), 32'd0);
        checkOutput("req_ready_back", 32'(req_ready[idx]), 32'd1);
        checkOutput("write_count", 32'(wr_count[idx] - wc0), 32'(wen && !err));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] obs;
        int wc0;
        ram_init = 1'b1;
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_wen[i] = 1'b0; req_size[i] = 2'b00;
            req_unsigned[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0; resp_ready[i] = 1'b0;
            for (int w = 0; w < RAM_WORDS; w++)
                for (int b = 0; b < 4; b++) ref_mem[i][4*w + b] = init_word(w) >> (8 * b);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        ram_init = 1'b0;
        for (int i = 0; i < N; i++) rst[i] = 1'b0;

        $display("[TB] reset state");
        for (int i = 0; i < N; i++) begin
            checkOutput("rst_req_ready", 32'(req_ready[i]), 32'd1);
            checkOutput("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
            checkOutput("rst_resp_err", 32'(resp_err[i]), 32'd0);
            checkOutput("rst_resp_rdata", resp_rdata[i], 32'd0);
            checkOutput("rst_dmem_valid", 32'(dmem_valid[i]), 32'd0);
            checkOutput("rst_dmem_wen", 32'(dmem_wen[i]), 32'd0);
            checkOutput("rst_dmem_wmask", 32'(dmem_wmask[i]), 32'd0);
            checkOutput("rst_dmem_addr", dmem_addr[i], 32'd0);
            checkOutput("rst_dmem_wdata", dmem_wdata[i], 32'd0);
        end

        $display("[TB] directed halfword loads");
        applyStimulus(0, 1'b0, 2'b01, 1'b0, 32'h8000_0002, 32'h0, 0, obs);
        checkOutput("lh_value", obs, 32'hFFFF_8001);
        applyStimulus(0, 1'b0, 2'b01, 1'b1, 32'h8000_0002, 32'h0, 0, obs);
        checkOutput("lhu_value", obs, 32'h0000_8001);

        $display("[TB] directed byte store");
        applyStimulus(0, 1'b1, 2'b00, 1'b0, 32'h8000_0003, 32'h0000_00AB, 0, obs);
        checkOutput("sb_ram_word", ram[0][0], 32'hAB01_1234);

        $display("[TB] latency-3 word load with held response, then word store");
        applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0, 3, obs);
        checkOutput("lw_value", obs, 32'h8001_1234);
        applyStimulus(1, 1'b1, 2'b10, 1'b0, 32'h8000_0020, 32'hCAFE_F00D, 0, obs);
        checkOutput("sw_ram_word", ram[1][8], 32'hCAFE_F00D);

        $display("[TB] reset during a latency-3 store");
        @(negedge clk);
        wc0 = wr_count[1];
        req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_size[1] = 2'b10;
        req_addr[1] = 32'h8000_0010; req_wdata[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid[1] = 1'b0;
        checkOutput("abort_c1_valid", 32'(dmem_valid[1]), 32'd1);
        checkOutput("abort_c1_wen", 32'(dmem_wen[1]), 32'd0);
        @(negedge clk);
        checkOutput("abort_c2_wen", 32'(dmem_wen[1]), 32'd0);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        checkOutput("abort_c3_valid", 32'(dmem_valid[1]), 32'd0);
        checkOutput("abort_c3_wen", 32'(dmem_wen[1]), 32'd0);
        checkOutput("abort_c3_ready", 32'(req_ready[1]), 32'd1);
        checkOutput("abort_c3_resp", 32'(resp_valid[1]), 32'd0);
        checkOutput("abort_writes", 32'(wr_count[1] - wc0), 32'd0);
        applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 0, obs);
        checkOutput("abort_ram_kept", obs, init_word(4));

        $display("[TB] misaligned word load");
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h8000_0001, 32'h0, 1, obs);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 80; t++) begin
            applyStimulus($urandom_range(0, 1), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 32'h8000_0000 | 32'($urandom_range(0, 255)),
                          $urandom(), $urandom_range(0, 2), obs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
Load/store initiator that drives the data-memory port of the 2-read/1-write RAM model from the core's execute stage.
- Takes one load/store request per transaction.
- Converts it to a word-aligned access with byte mask and shifted write data.
- Holds the access for a configurable number of cycles.
- Returns aligned, sign- or zero-extended load data over a valid/ready response channel.
- Supports one outstanding transaction; sits between the EXU and the RAM's dmem_* ports.

Parameters:
MEM_LATENCY, 1, cycles dmem_valid is held per access (minimum 1); load data is sampled on the last cycle.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_wen  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  zero-extend load (lbu/lhu)
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-justified
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  extended load data; 0 for stores
resp_err  out  1  misaligned/reserved-size error (constant 0 without the optional feature)
dmem_valid  out  1  memory access active
dmem_addr  out  32  {addr[31:2],2'b00}
dmem_wdata  out  32  store data shifted to byte lanes
dmem_wen  out  1  write strobe
dmem_wmask  out  4  byte-lane mask
dmem_rdata  in  32  combinational read data from RAM

Behaviour:
- Clock is clk. Reset is rst: one clock, synchronous, active-high.
- Reset values: state IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0; dmem_valid, dmem_wen, dmem_wmask, dmem_addr, dmem_wdata all 0.
- FSM states IDLE, ACCESS, RESP.
  - IDLE: req_ready=1. On req_valid, capture wen, size, unsigned and addr, plus the precomputed mask/shifted wdata. Clear cnt. Next state ACCESS.
  - ACCESS: req_ready=0; dmem_valid=1; dmem_addr, dmem_wdata and dmem_wmask come from registers. cnt increments each cycle. When cnt==MEM_LATENCY-1: latch extracted load data (0 for stores), next state RESP.
  - RESP: resp_valid=1; resp_rdata and resp_err are held stable until resp_ready. On resp_ready, next state IDLE. No same-cycle accept of a new request; req_ready=0 in RESP.
- dmem_wen=1 only when state==ACCESS, store, and cnt==MEM_LATENCY-1. The RAM writes on every posedge with valid&wen, so each store writes exactly once.
- Latency: accept at cycle 0; dmem_valid during cycles 1..MEM_LATENCY; resp_valid from cycle MEM_LATENCY+1. Throughput is one transaction per MEM_LATENCY+2 cycles at best.
- Lane rules, with off=addr[1:0]:
  - wmask: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
  - dmem_wdata = req_wdata<<(8*off).
  - Load: raw = dmem_rdata>>(8*off), truncated to size. Byte/half are sign-extended unless req_unsigned; word is unchanged.
- Size 11 without the macro: treated as word.
- Reset mid-ACCESS: the next cycle is IDLE with dmem_valid=0. No write is issued unless wen had already fired on the final cycle.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - Errors: half with off[0]=1, word with off!=0, or size 11.
  - On an error, IDLE goes directly to RESP with resp_err=1 and resp_rdata=0; dmem_valid is never asserted.
- Undefined:
  - Address is aligned down to the access size (half clears bit 0, word clears bits 1:0) before lane computation.
  - resp_err is tied 0.

Decomposition:
- Shared package lsu_pkg holds:
  - typedef lsu_size_e (SZ_B, SZ_H, SZ_W, SZ_RSV);
  - typedef lsu_state_e (IDLE, ACCESS, RESP);
  - localparam BYTE_MASK_W=4.
- One combinational sub-module, lsu_align: mask generation, wdata shift, load extract/extend. It is reused by the top for both directions.

Test Plan:
- sb addr 0x80000003 wdata 0x000000AB, MEM_LATENCY=1 -> dmem_addr 0x80000000, wmask 4'b1000, dmem_wdata 0xAB000000, dmem_wen high exactly 1 cycle; resp_valid at cycle 2, resp_rdata 0.
- lh addr 0x80000002, dmem_rdata 0x80011234 -> resp_rdata 0xFFFF8001. Same access as lhu -> 0x00008001.
- lw, MEM_LATENCY=3, resp_ready low 3 cycles -> dmem_valid cycles 1-3, resp_valid held cycles 4-7, rdata stable, req_ready 0 until the cycle after the handshake.
- sw, MEM_LATENCY=3 -> dmem_wen high only in cycle 3; RAM word written once.
- rst asserted in cycle 2 of a MEM_LATENCY=3 store -> cycle 3 has dmem_valid=0, dmem_wen never high, req_ready=1.
- lw addr 0x80000001:
  - with LSU_MISALIGN_TRAP_EN -> no dmem_valid, resp_valid with resp_err=1 at cycle 1;
  - without -> dmem_addr 0x80000000, resp_err=0.
